// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame : baud-rate UART transmitter (start, LSB-first data, optional
// parity, stop). Optional one-entry holding register via UART_TX_HOLD_REG_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_UART_TX,
  input  logic                  RST_UART_TX,
  input  logic [DATA_WIDTH-1:0] P_DATA_UART_TX,
  input  logic                  DATA_VALID_UART_TX,
  input  logic                  PAR_EN_UART_TX,
  input  logic                  PAR_TYP_UART_TX,
  output logic                  READY_UART_TX,
  output logic                  TX_OUT_UART_TX,
  output logic                  BUSY_UART_TX
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  accept;
  logic                  frame_slot;
  logic                  start_now;
  logic [DATA_WIDTH-1:0] start_data;
  logic                  start_pen;
  logic                  start_ptyp;

  assign frame_slot = (state == IDLE) || (state == STOP);

`ifdef UART_TX_HOLD_REG_EN
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_pen;
  logic                  hold_ptyp;
  logic                  hold_full;
  logic                  start_from_hold;
  logic                  start_from_in;
  logic                  load_hold;

  assign READY_UART_TX   = !hold_full;
  assign accept          = DATA_VALID_UART_TX && READY_UART_TX;
  assign start_from_hold = frame_slot && hold_full;
  // With an empty hold register a byte arriving at a frame boundary bypasses it.
  assign start_from_in   = frame_slot && !hold_full && accept;
  assign load_hold       = accept && !start_from_in;

  always_comb begin
    start_now  = start_from_hold || start_from_in;
    start_data = P_DATA_UART_TX;
    start_pen  = PAR_EN_UART_TX;
    start_ptyp = PAR_TYP_UART_TX;
    if (hold_full) begin
      start_data = hold_data;
      start_pen  = hold_pen;
      start_ptyp = hold_ptyp;
    end
  end

  always_ff @(posedge CLK_UART_TX or posedge RST_UART_TX) begin
    if (RST_UART_TX) begin
      hold_data <= '0;
      hold_pen  <= 1'b0;
      hold_ptyp <= 1'b0;
      hold_full <= 1'b0;
    end else if (load_hold) begin
      hold_data <= P_DATA_UART_TX;
      hold_pen  <= PAR_EN_UART_TX;
      hold_ptyp <= PAR_TYP_UART_TX;
      hold_full <= 1'b1;
    end else if (start_from_hold) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign READY_UART_TX = frame_slot;
  assign accept        = DATA_VALID_UART_TX && READY_UART_TX;

  always_comb begin
    start_now  = accept;
    start_data = P_DATA_UART_TX;
    start_pen  = PAR_EN_UART_TX;
    start_ptyp = PAR_TYP_UART_TX;
  end
`endif

  always_ff @(posedge CLK_UART_TX or posedge RST_UART_TX) begin
    if (RST_UART_TX) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (start_now) begin
            state     <= START;
            shreg     <= start_data;
            par_en_q  <= start_pen;
            par_bit_q <= (^start_data) ^ start_ptyp;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            state  <= IDLE;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          tx_q    <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit_q;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          state <= STOP;
          tx_q  <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT_UART_TX = tx_q;
  assign BUSY_UART_TX   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame : scoreboard bench; stimulus queues expected frames, a
// line monitor reassembles each serial frame and compares.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_frame;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pdata;
  logic         valid;
  logic         pen;
  logic         ptyp;
  logic         ready;
  logic         tx;
  logic         busy;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK_UART_TX        (clk),
    .RST_UART_TX        (rst),
    .P_DATA_UART_TX     (pdata),
    .DATA_VALID_UART_TX (valid),
    .PAR_EN_UART_TX     (pen),
    .PAR_TYP_UART_TX    (ptyp),
    .READY_UART_TX      (ready),
    .TX_OUT_UART_TX     (tx),
    .BUSY_UART_TX       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    bit           pen;
    bit           pbit;
    bit           b2b;
    bit           abort_ok;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   frames_seen = 0;
  int   frames_aborted = 0;
  int   n_exp = 0;
  bit   mon_busy = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endfunction

  function automatic void fail(string name);
    checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // Line monitor: an idle-high line must show BUSY=0/READY=1; a low bit opens a frame.
  initial begin : monitor
    exp_t         e;
    logic [W-1:0] d;
    int           last_stop;
    int           c0;
    bit           aborted;
    last_stop = -100;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (tx === 1'b1) begin
        check("idle_busy", busy, 0);
        check("idle_ready", ready, 1);
      end else begin
        mon_busy = 1'b1;
        c0 = cyc;
        check("start_busy", busy, 1);
        if (q.size() == 0) begin
          fail("unexpected_frame");
          e.data = '0; e.pen = 1'b0; e.pbit = 1'b0; e.b2b = 1'b0; e.abort_ok = 1'b0;
        end else begin
          e = q.pop_front();
        end
        if (e.b2b) check("b2b_start_cycle", c0, last_stop + 1);
        aborted = 1'b0;
        d = '0;
        for (int i = 0; i < W; i++) begin
          @(negedge clk);
          if (rst) begin aborted = 1'b1; break; end
          d[i] = tx;
          check("data_busy", busy, 1);
        end
        if (!aborted && e.pen) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          else begin
            check("parity_bit", tx, e.pbit);
            check("parity_busy", busy, 1);
          end
        end
        if (!aborted) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          else begin
            check("stop_bit", tx, 1);
            check("stop_busy", busy, 1);
            last_stop = cyc;
          end
        end
        if (aborted) begin
          check("abort_expected", e.abort_ok, 1);
          frames_aborted++;
        end else begin
          check("frame_data", d, e.data);
          frames_seen++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit pe, input bit pt,
                      input bit ep, input bit bb, input bit ab);
    exp_t e;
    bit   r;
    e.data = d; e.pen = pe; e.pbit = ep; e.b2b = bb; e.abort_ok = ab;
    q.push_back(e);
    if (!ab) n_exp++;
    @(negedge clk);
    pdata = d; pen = pe; ptyp = pt; valid = 1'b1;
    r = 1'b0;
    for (int k = 0; k < 50 && !r; k++) begin
      r = ready;
      @(posedge clk);
    end
    if (!r) fail("accept_timeout");
  endtask

  // Drop VALID and scramble the other inputs: an accepted frame must not notice.
  task automatic drop();
    @(negedge clk);
    valid = 1'b0;
    pdata = W'($urandom);
    pen   = ~pen;
    ptyp  = ~ptyp;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !mon_busy && busy === 1'b0) done = 1'b1;
    end
    if (!done) fail("idle_timeout");
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    int e0;
    rst = 1'b1; valid = 1'b0; pdata = '0; pen = 1'b0; ptyp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0xA5 = 1010_0101, four ones: even parity 0, odd parity 1.
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); drop(); wait_idle();
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); drop(); wait_idle();
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); drop(); wait_idle();
    // 0x07 has three ones: even parity 1.
    send(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); drop(); wait_idle();

    // VALID held across two frames: second start directly after first stop.
    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drop(); wait_idle();

    // Asynchronous reset while data bit 4 of 0x3C is on the line.
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drop();
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_tx", tx, 1);
    check("midframe_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    // 0x81 has two ones: odd parity 1.
    send(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); drop(); wait_idle();

`ifdef UART_TX_HOLD_REG_EN
    send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 e0 = cyc;
    drop();
    repeat (3) @(posedge clk);
    check("hold_ready_before", ready, 1);
    send(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("hold_ready_after_accept", ready, 0);
    drop();
    for (int k = 0; k < 20 && cyc != e0 + 9; k++) begin
      @(posedge clk);
      #1;
    end
    check("hold_ready_in_stop", ready, 0);
    @(posedge clk);
    #1 check("hold_ready_after_stop", ready, 1);
    wait_idle();
`else
    e0 = 0;
`endif

    check("frames_completed", frames_seen, n_exp);
    check("frames_aborted", frames_aborted, 1);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit path: accepts a parallel byte through a valid/ready handshake and emits one serial frame on TX_OUT_UART_TX.
- Frame order: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Counterpart of the receive-side deserializer: bit order and parity conventions are chosen so a frame sent here reassembles to the same byte there.
- Clocked at the baud rate: one bit period = one clock cycle.

Parameters:
- DATA_WIDTH, 8, width of the parallel data word and the number of data bits per frame.

Ports:
- CLK_UART_TX  input  1  baud-rate clock
- RST_UART_TX  input  1  asynchronous, active-high reset
- P_DATA_UART_TX  input  DATA_WIDTH  byte to transmit
- DATA_VALID_UART_TX  input  1  P_DATA holds a byte to send
- PAR_EN_UART_TX  input  1  1 = insert parity bit
- PAR_TYP_UART_TX  input  1  0 = even parity, 1 = odd parity
- READY_UART_TX  output  1  byte accepted on this edge if VALID is also high (combinational from state)
- TX_OUT_UART_TX  output  1  serial line, registered, idles high
- BUSY_UART_TX  output  1  frame in progress, registered

Behaviour:
- Reset (async, active-high), including mid-frame:
  - TX_OUT=1, BUSY=0, state=IDLE, bit counter=0, shift register=0.
  - Any frame in progress is abandoned; no stop bit is completed.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept = DATA_VALID && READY at a rising edge. Without the optional feature, READY=1 in IDLE and in STOP.
- On accept:
  - P_DATA is latched into the shift register; PAR_EN/PAR_TYP are latched for the whole frame.
  - Parity is computed from the latched data: even → XOR of the data bits; odd → inverted XOR.
  - Next state = START. Later changes to inputs do not affect the frame.
- Timing relative to the accept edge E0:
  - START: TX_OUT=0, BUSY=1 from E0.
  - DATA: from E0+1, one bit per cycle, LSB first, for DATA_WIDTH cycles; bit counter 0..DATA_WIDTH-1.
  - PARITY: present only if the latched PAR_EN=1; one cycle, TX_OUT = parity bit.
  - STOP: one cycle, TX_OUT=1.
- Frame length: 10 cycles without parity, 11 with (DATA_WIDTH=8).
- Leaving STOP:
  - If an accept occurs on the STOP edge → START, back-to-back with no idle gap; BUSY stays 1.
  - Otherwise → IDLE with TX_OUT=1, BUSY=0.
- DATA_VALID while not READY is ignored: no accept, no side effects. Sender must hold VALID until accepted.
- DATA_VALID held continuously → continuous back-to-back frames, with a fresh accept each STOP.
- BUSY is low only in IDLE.

Optional Feature:
- Macro UART_TX_HOLD_REG_EN.
- When defined:
  - One-entry holding register (data + PAR_EN + PAR_TYP + full flag).
  - READY = !hold_full, independent of the state machine.
  - An accept while a frame is active loads the holding register.
  - On the STOP edge with hold_full=1, the held byte starts the next frame back-to-back and hold_full clears.
  - Accept in IDLE with the hold register empty starts immediately (bypass); the byte is not written to the hold register.
  - Simultaneous hold-to-shift transfer and new accept on the same STOP edge: the new byte is written to the hold register and hold_full stays 1.
  - Reset clears hold_full.
- When undefined: no holding register; READY as described in Behaviour.

Test Plan:
- Reset then idle 5 cycles → TX_OUT=1, BUSY=0, READY=1 throughout.
- P_DATA=0xA5, PAR_EN=0, one-cycle VALID in IDLE → TX_OUT per cycle from E0: 0,1,0,1,0,0,1,0,1,1; BUSY high for 10 cycles, then 0.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 → parity bit 0, 11-cycle frame; repeat with PAR_TYP=1 → parity bit 1.
- VALID held high, data 0x0F then 0xF0 → two frames with no idle cycle between them; second start bit immediately after first stop bit; BUSY stays 1 across the boundary.
- Assert RST at data bit 4 of a 0x3C frame → TX_OUT=1 and BUSY=0 immediately (asynchronous); after release a new 0x81 frame transmits correctly.
- UART_TX_HOLD_REG_EN: send 0x11; during its DATA phase present 0x22 → READY was 1 and goes 0 after accept; 0x22 frame follows 0x11 back-to-back; READY returns to 1 on the STOP edge.
